// File: rtl/hps_reset_pkg.sv
// Shared definitions for the HPS warm/cold reset responder: state encoding,
// parameter defaults and the state-to-output decode used by the top level.
package hps_reset_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_ACK     = 3'd2,
        ST_COLD    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_ACK_TIMEOUT = 1024;
    localparam int DEF_RST_EXT     = 16;

    typedef struct packed {
        logic ack_n;
        logic quiesce;
        logic fpga_reset_n;
    } out_t;

    // One counter serves both the quiesce timeout and the release stretch.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

    function automatic out_t decode_outputs(input state_t s);
        out_t o;
        o.ack_n        = (s != ST_ACK);
        o.quiesce      = (s == ST_QUIESCE) || (s == ST_ACK);
        o.fpga_reset_n = (s == ST_IDLE) || (s == ST_QUIESCE);
        return o;
    endfunction

endpackage

// File: rtl/hps_reset_sync.sv
// Single-bit multi-stage synchronizer; every stage resets to 1 so an
// active-low HPS request never appears asserted out of reset.
module hps_reset_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/hps_reset_responder.sv
// Answers HPS warm-reset requests by quiescing the fabric, acknowledging,
// and stretching fpga_reset_n; an HPS cold reset overrides everything.
module hps_reset_responder
    import hps_reset_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int RST_EXT     = DEF_RST_EXT
) (
    input  logic clock_clk,
    input  logic reset_reset_n,
    input  logic h2f_pending_rst_req_n,
    input  logic h2f_cold_rst_n,
    input  logic fpga_idle,
    output logic f2h_pending_rst_ack_n,
    output logic fpga_quiesce,
    output logic fpga_reset_n,
    output logic timeout_flag
);

    localparam int CW      = cnt_width(ACK_TIMEOUT, RST_EXT);
    localparam int CNT_MAX = (ACK_TIMEOUT > RST_EXT) ? ACK_TIMEOUT : RST_EXT;
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] REL_LAST = CW'(RST_EXT - 1);
    localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          w_reqS;
    logic          w_coldS;
    state_t        r_state;
    state_t        w_stateNext;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cntNext;
    logic [CW-1:0] w_cntInc;
    logic          w_setTimeout;
    logic          w_clrTimeout;
    out_t          w_outNext;
    logic          r_ackN;
    logic          r_quiesce;
    logic          r_fpgaRstN;
    logic          r_timeout;

    hps_reset_sync #(.STAGES(SYNC_STAGES)) u_reqSync (
        .i_clk   (clock_clk),
        .i_rst_n (reset_reset_n),
        .i_d     (h2f_pending_rst_req_n),
        .o_q     (w_reqS)
    );

    hps_reset_sync #(.STAGES(SYNC_STAGES)) u_coldSync (
        .i_clk   (clock_clk),
        .i_rst_n (reset_reset_n),
        .i_d     (h2f_cold_rst_n),
        .o_q     (w_coldS)
    );

    assign w_cntInc = (r_cnt == CNT_TOP) ? r_cnt : r_cnt + CNT_ONE;

    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_setTimeout = 1'b0;
        w_clrTimeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_reqS) begin
                    w_stateNext  = ST_QUIESCE;
                    w_cntNext    = '0;
                    w_clrTimeout = 1'b1;
                end
            end
            ST_QUIESCE: begin
                w_cntNext = w_cntInc;
                if (w_reqS) begin
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                end else if (fpga_idle) begin
                    w_stateNext = ST_ACK;
                    w_cntNext   = '0;
                end else if (r_cnt == ACK_LAST) begin
                    w_stateNext  = ST_ACK;
                    w_cntNext    = '0;
                    w_setTimeout = 1'b1;
                end
            end
            ST_ACK: begin
                if (w_reqS) begin
                    w_stateNext = ST_RELEASE;
                    w_cntNext   = '0;
                end
            end
            ST_COLD: begin
                if (w_coldS) begin
                    w_stateNext = ST_RELEASE;
                    w_cntNext   = '0;
                end
            end
            ST_RELEASE: begin
                if (r_cnt == REL_LAST) begin
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = w_cntInc;
                end
            end
            default: begin
                w_stateNext = ST_RELEASE;
                w_cntNext   = '0;
            end
        endcase
        // Cold reset wins over any handshake in progress, including a timeout.
        if (!w_coldS) begin
            w_stateNext  = ST_COLD;
            w_cntNext    = '0;
            w_setTimeout = 1'b0;
            w_clrTimeout = 1'b0;
        end
    end

    assign w_outNext = decode_outputs(w_stateNext);

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= ST_RELEASE;
            r_cnt      <= '0;
            r_ackN     <= 1'b1;
            r_quiesce  <= 1'b0;
            r_fpgaRstN <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_ackN     <= w_outNext.ack_n;
            r_quiesce  <= w_outNext.quiesce;
            r_fpgaRstN <= w_outNext.fpga_reset_n;
            if (w_setTimeout) begin
                r_timeout <= 1'b1;
            end else if (w_clrTimeout) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign f2h_pending_rst_ack_n = r_ackN;
    assign fpga_quiesce          = r_quiesce;
    assign fpga_reset_n          = r_fpgaRstN;
    assign timeout_flag          = r_timeout;

endmodule

// File: tb/tb_hps_reset_responder.sv
// Self-checking bench for hps_reset_responder: a flag-based handshake model
// compared every cycle, plus directed scenarios with hand-computed timings.
module tb_hps_reset_responder;

    localparam int SYNC_STAGES = 2;
    localparam int ACK_TIMEOUT = 8;
    localparam int RST_EXT     = 4;

    localparam int SEL_ACKN    = 0;
    localparam int SEL_QUIESCE = 1;
    localparam int SEL_RSTN    = 2;
    localparam int SEL_TIMEOUT = 3;

    logic clock_clk;
    logic reset_reset_n;
    logic h2f_pending_rst_req_n;
    logic h2f_cold_rst_n;
    logic fpga_idle;
    logic f2h_pending_rst_ack_n;
    logic fpga_quiesce;
    logic fpga_reset_n;
    logic timeout_flag;

    int checks;
    int errors;
    bit cmpEn;

    hps_reset_responder #(
        .SYNC_STAGES (SYNC_STAGES),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .RST_EXT     (RST_EXT)
    ) dut (
        .clock_clk             (clock_clk),
        .reset_reset_n         (reset_reset_n),
        .h2f_pending_rst_req_n (h2f_pending_rst_req_n),
        .h2f_cold_rst_n        (h2f_cold_rst_n),
        .fpga_idle             (fpga_idle),
        .f2h_pending_rst_ack_n (f2h_pending_rst_ack_n),
        .fpga_quiesce          (fpga_quiesce),
        .fpga_reset_n          (fpga_reset_n),
        .timeout_flag          (timeout_flag)
    );

    initial clock_clk = 1'b0;
    always #5 clock_clk = ~clock_clk;

    // Behavioural model: synced inputs are plain delay lines, and the
    // handshake is tracked as "acked / quiescing / cold held / release left".
    logic [SYNC_STAGES-1:0] mReqPipe;
    logic [SYNC_STAGES-1:0] mColdPipe;
    bit mAcked;
    bit mInQuiesce;
    bit mColdHeld;
    bit mTimeout;
    int mQuiesceAge;
    int mReleaseLeft;

    always @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mReqPipe     <= '1;
            mColdPipe    <= '1;
            mAcked       <= 1'b0;
            mInQuiesce   <= 1'b0;
            mColdHeld    <= 1'b0;
            mTimeout     <= 1'b0;
            mQuiesceAge  <= 0;
            mReleaseLeft <= RST_EXT;
        end else begin
            mReqPipe  <= {mReqPipe[SYNC_STAGES-2:0], h2f_pending_rst_req_n};
            mColdPipe <= {mColdPipe[SYNC_STAGES-2:0], h2f_cold_rst_n};
            if (!mColdPipe[SYNC_STAGES-1]) begin
                mAcked       <= 1'b0;
                mInQuiesce   <= 1'b0;
                mReleaseLeft <= 0;
                mColdHeld    <= 1'b1;
            end else if (mColdHeld) begin
                mColdHeld    <= 1'b0;
                mReleaseLeft <= RST_EXT;
            end else if (mReleaseLeft > 0) begin
                mReleaseLeft <= mReleaseLeft - 1;
            end else if (mAcked) begin
                if (mReqPipe[SYNC_STAGES-1]) begin
                    mAcked       <= 1'b0;
                    mReleaseLeft <= RST_EXT;
                end
            end else if (mInQuiesce) begin
                if (mReqPipe[SYNC_STAGES-1]) begin
                    mInQuiesce <= 1'b0;
                end else if (fpga_idle || mQuiesceAge == ACK_TIMEOUT - 1) begin
                    mAcked     <= 1'b1;
                    mInQuiesce <= 1'b0;
                    if (!fpga_idle) mTimeout <= 1'b1;
                end else begin
                    mQuiesceAge <= mQuiesceAge + 1;
                end
            end else if (!mReqPipe[SYNC_STAGES-1]) begin
                mInQuiesce  <= 1'b1;
                mQuiesceAge <= 0;
                mTimeout    <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock_clk) begin
        if (cmpEn) begin
            checkOutput("modelAckN",    32'(f2h_pending_rst_ack_n), 32'(!mAcked));
            checkOutput("modelQuiesce", 32'(fpga_quiesce),          32'(mInQuiesce || mAcked));
            checkOutput("modelRstN",    32'(fpga_reset_n),
                        32'(!(mAcked || mColdHeld || mReleaseLeft > 0)));
            checkOutput("modelTimeout", 32'(timeout_flag),          32'(mTimeout));
        end
    end

    function automatic logic readOut(input int sel);
        case (sel)
            SEL_ACKN:    return f2h_pending_rst_ack_n;
            SEL_QUIESCE: return fpga_quiesce;
            SEL_RSTN:    return fpga_reset_n;
            default:     return timeout_flag;
        endcase
    endfunction

    task automatic applyStimulus(input logic reqN, input logic coldN, input logic idle);
        h2f_pending_rst_req_n = reqN;
        h2f_cold_rst_n        = coldN;
        fpga_idle             = idle;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock_clk);
    endtask

    // Waits (bounded) until an output reaches a level; a timeout is a failure.
    task automatic waitLevel(input int sel, input logic level, input int limit, input string name);
        int n = 0;
        while (readOut(sel) !== level && n < limit) begin
            @(negedge clock_clk);
            n++;
        end
        checkOutput(name, 32'(readOut(sel)), 32'(level));
    endtask

    // Counts consecutive negedge samples (starting now) at which an output holds a level.
    task automatic runLength(input int sel, input logic level, input int limit, output int n);
        n = 0;
        while (readOut(sel) === level && n < limit) begin
            n++;
            @(negedge clock_clk);
        end
    endtask

    initial begin
        int n;
        bit ackLowSeen;
        bit rstLowSeen;
        checks = 0;
        errors = 0;
        cmpEn  = 1'b0;
        reset_reset_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(2);
        checkOutput("resetAckN",    32'(f2h_pending_rst_ack_n), 32'd1);
        checkOutput("resetQuiesce", 32'(fpga_quiesce),          32'd0);
        checkOutput("resetRstN",    32'(fpga_reset_n),          32'd0);
        checkOutput("resetTimeout", 32'(timeout_flag),          32'd0);
        cmpEn = 1'b1;

        // Power-on stretch after reset release
        reset_reset_n = 1'b1;
        runLength(SEL_RSTN, 1'b0, 20, n);
        checkOutput("porStretch", 32'(n), 32'd4);

        // Request answered by fabric idle after three quiesce cycles
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick(2);
        checkOutput("quiesceEarly", 32'(fpga_quiesce), 32'd0);
        tick(1);
        checkOutput("quiesceLatency", 32'(fpga_quiesce), 32'd1);
        tick(2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        checkOutput("ackAfterIdle",   32'(f2h_pending_rst_ack_n), 32'd0);
        checkOutput("ackQuiesce",     32'(fpga_quiesce),          32'd1);
        checkOutput("ackRstN",        32'(fpga_reset_n),          32'd0);
        checkOutput("ackNoTimeout",   32'(timeout_flag),          32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runLength(SEL_ACKN, 1'b0, 20, n);
        checkOutput("ackHoldAfterWithdraw", 32'(n), 32'd3);
        runLength(SEL_RSTN, 1'b0, 20, n);
        checkOutput("releaseStretch", 32'(n), 32'd4);

        // Fabric never idle: forced ack after the full timeout
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitLevel(SEL_QUIESCE, 1'b1, 10, "quiesceRiseTimeout");
        runLength(SEL_ACKN, 1'b1, 30, n);
        checkOutput("timeoutQuiesceCycles", 32'(n), 32'd8);
        checkOutput("timeoutAck",  32'(f2h_pending_rst_ack_n), 32'd0);
        checkOutput("timeoutFlag", 32'(timeout_flag),          32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitLevel(SEL_RSTN, 1'b1, 20, "idleAfterTimeout");
        checkOutput("timeoutSticky", 32'(timeout_flag), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitLevel(SEL_QUIESCE, 1'b1, 10, "quiesceRiseNewReq");
        checkOutput("timeoutClearOnNewReq", 32'(timeout_flag), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitLevel(SEL_ACKN, 1'b0, 10, "ackNewReq");
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitLevel(SEL_RSTN, 1'b1, 20, "idleAfterNewReq");

        // Request withdrawn after two quiesce cycles
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitLevel(SEL_QUIESCE, 1'b1, 10, "quiesceRiseWithdraw");
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        ackLowSeen = 1'b0;
        rstLowSeen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (f2h_pending_rst_ack_n === 1'b0) ackLowSeen = 1'b1;
            if (fpga_reset_n === 1'b0) rstLowSeen = 1'b1;
            tick(1);
        end
        checkOutput("withdrawNoAck",     32'(ackLowSeen),   32'd0);
        checkOutput("withdrawNoReset",   32'(rstLowSeen),   32'd0);
        checkOutput("withdrawQuiesceOff", 32'(fpga_quiesce), 32'd0);

        // Cold reset during ACK
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitLevel(SEL_ACKN, 1'b0, 10, "ackBeforeCold");
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);
        checkOutput("coldNotYet", 32'(f2h_pending_rst_ack_n), 32'd0);
        tick(1);
        checkOutput("coldAckN",    32'(f2h_pending_rst_ack_n), 32'd1);
        checkOutput("coldRstN",    32'(fpga_reset_n),          32'd0);
        checkOutput("coldQuiesce", 32'(fpga_quiesce),          32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(1);
        runLength(SEL_RSTN, 1'b0, 20, n);
        checkOutput("coldReleaseLow", 32'(n), 32'd6);

        // Reset pulse in the middle of a handshake
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitLevel(SEL_ACKN, 1'b0, 10, "ackBeforeReset");
        #2 reset_reset_n = 1'b0;
        #1;
        checkOutput("midResetAckN",    32'(f2h_pending_rst_ack_n), 32'd1);
        checkOutput("midResetRstN",    32'(fpga_reset_n),          32'd0);
        checkOutput("midResetQuiesce", 32'(fpga_quiesce),          32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clock_clk);
        reset_reset_n = 1'b1;
        runLength(SEL_RSTN, 1'b0, 20, n);
        checkOutput("porAfterPulse", 32'(n), 32'd4);
        tick(3);

        cmpEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
